// File: rtl/bram_line_reader.sv
// ============================================================================
// Module      : bram_line_reader
// Description : Fetches packed BURST_LEN x DATA_W lines from BRAM port B and
//               streams them lane by lane (lane 0 first) on valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_line_reader #(
    parameter int DATA_W    = 16,
    parameter int BURST_LEN = 8,
    parameter int ADDR_W    = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [ADDR_W:0]             num_lines,
    output logic                        busy,
    output logic                        done,
    output logic [ADDR_W-1:0]           ram_rd_addr,
    input  logic [DATA_W*BURST_LEN-1:0] ram_rd_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last
);

    localparam int c_line_w = DATA_W * BURST_LEN;
    localparam int c_lane_w = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(BURST_LEN - 1);
    localparam logic [ADDR_W:0]     c_one_line  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [ADDR_W-1:0]     next_addr_q, next_addr_d;
    logic [ADDR_W:0]       num_q, num_d;
    logic [ADDR_W:0]       issued_q, issued_d;
    logic [ADDR_W:0]       left_q, left_d;
    logic [c_line_w-1:0]   cur_q, cur_d;
    logic                  cur_vld_q, cur_vld_d;
    logic [c_lane_w-1:0]   lane_q, lane_d;
    logic [c_line_w-1:0]   pf_q, pf_d;
    logic                  pf_full_q, pf_full_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_vld_q, rd_vld_d;

    logic w_hs;
    logic w_line_end;
    logic w_last_line;
    logic w_issue;

    assign w_hs        = cur_vld_q & out_ready;
    assign w_line_end  = w_hs & (lane_q == c_last_lane);
    assign w_last_line = (left_q == c_one_line);

    // A read stays "pending" until its data has been captured, so only one
    // read is ever in flight.
    assign w_issue = (state_q == S_RUN) && (issued_q < num_q) && !rd_pend_q
                     && !rd_vld_q && (!pf_full_q || !cur_vld_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        next_addr_d = next_addr_q;
        num_d       = num_q;
        issued_d    = issued_q;
        left_d      = left_q;
        cur_d       = cur_q;
        cur_vld_d   = cur_vld_q;
        lane_d      = lane_q;
        pf_d        = pf_q;
        pf_full_d   = pf_full_q;
        rd_pend_d   = 1'b0;
        rd_vld_d    = rd_pend_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_d       = num_lines;
                    left_d      = num_lines;
                    next_addr_d = base_addr + 1'b1;
                    lane_d      = '0;
                    state_d     = S_RUN;
                    if (num_lines != '0) begin
                        addr_d    = base_addr;
                        rd_pend_d = 1'b1;
                        issued_d  = c_one_line;
                    end else begin
                        issued_d  = '0;
                    end
                end
            end

            S_RUN: begin
                if (w_issue) begin
                    addr_d      = next_addr_q;
                    next_addr_d = next_addr_q + 1'b1;
                    rd_pend_d   = 1'b1;
                    issued_d    = issued_q + 1'b1;
                end

                if (w_hs) begin
                    lane_d = w_line_end ? '0 : lane_q + 1'b1;
                end

                // cur refills from prefetch first so lines follow with no bubble.
                if (!cur_vld_q || w_line_end) begin
                    if (pf_full_q) begin
                        cur_d     = pf_q;
                        cur_vld_d = 1'b1;
                        if (rd_vld_q) begin
                            pf_d = ram_rd_data;
                        end else begin
                            pf_full_d = 1'b0;
                        end
                    end else if (rd_vld_q) begin
                        cur_d     = ram_rd_data;
                        cur_vld_d = 1'b1;
                    end else begin
                        cur_vld_d = 1'b0;
                    end
                end else if (rd_vld_q) begin
                    pf_d      = ram_rd_data;
                    pf_full_d = 1'b1;
                end

                if (w_line_end) begin
                    left_d = left_q - 1'b1;
                end

                if ((w_line_end && w_last_line) || (left_q == '0)) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            next_addr_q <= '0;
            num_q       <= '0;
            issued_q    <= '0;
            left_q      <= '0;
            cur_q       <= '0;
            cur_vld_q   <= 1'b0;
            lane_q      <= '0;
            pf_q        <= '0;
            pf_full_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            next_addr_q <= next_addr_d;
            num_q       <= num_d;
            issued_q    <= issued_d;
            left_q      <= left_d;
            cur_q       <= cur_d;
            cur_vld_q   <= cur_vld_d;
            lane_q      <= lane_d;
            pf_q        <= pf_d;
            pf_full_q   <= pf_full_d;
            rd_pend_q   <= rd_pend_d;
            rd_vld_q    <= rd_vld_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = (state_q == S_FIN);
    assign ram_rd_addr = addr_q;
    assign out_valid   = cur_vld_q;
    assign out_data    = cur_vld_q ? cur_q[lane_q*DATA_W +: DATA_W] : '0;
    assign out_last    = cur_vld_q & (lane_q == c_last_lane) & w_last_line;

endmodule

`default_nettype wire

// File: tb/tb_bram_line_reader.sv
// ============================================================================
// Module      : tb_bram_line_reader
// Description : Table-driven bench for bram_line_reader; BRAM line k holds
//               lanes 16*k+lane.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_line_reader;

    localparam int DATA_W    = 16;
    localparam int BURST_LEN = 8;
    localparam int ADDR_W    = 10;
    localparam int c_budget  = 400;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        start = 1'b0;
    logic [ADDR_W-1:0]           base_addr = '0;
    logic [ADDR_W:0]             num_lines = '0;
    logic                        busy, done, out_valid, out_last;
    logic                        out_ready = 1'b1;
    logic [ADDR_W-1:0]           ram_rd_addr;
    logic [DATA_W*BURST_LEN-1:0] ram_rd_data = '0;
    logic [DATA_W-1:0]           out_data;

    logic [DATA_W*BURST_LEN-1:0] mem [0:(1<<ADDR_W)-1];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W:0]   num;
        bit                rand_ready;
        int                restart_t;
        int                exp_lanes;
        logic [ADDR_W-1:0] exp_last_addr;
    } vec_t;

    vec_t vecs [7];

    bram_line_reader #(
        .DATA_W   (DATA_W),
        .BURST_LEN(BURST_LEN),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_lines  (num_lines),
        .busy       (busy),
        .done       (done),
        .ram_rd_addr(ram_rd_addr),
        .ram_rd_data(ram_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int t, nhs, first_hs, last_hs, done_cnt, done_t, vld_extra;
        logic prev_stall, prev_last;
        logic [DATA_W-1:0] prev_data, exp_word;
        logic [ADDR_W-1:0] ln;
        string nm;
        nm = $sformatf("v%0d", idx);
        nhs = 0; first_hs = -1; last_hs = -1; done_cnt = 0; done_t = -1;
        vld_extra = 0; prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;

        @(negedge clk);
        base_addr = v.base;
        num_lines = v.num;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t = 1;
        chk(busy === 1'b1, {nm, "_busy_after_start"}, int'(busy), 1);

        while (t < c_budget && !(done_cnt > 0 && t >= done_t + 2)) begin
            start = (t == v.restart_t);
            if (t == v.restart_t) begin
                base_addr = 10'd100;
                num_lines = 11'd3;
            end
            out_ready = v.rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;

            if (prev_stall) begin
                chk(out_valid === 1'b1 && out_data === prev_data && out_last === prev_last,
                    {nm, "_stall_hold"}, int'(out_data), int'(prev_data));
            end
            if (out_last === 1'b1 && out_valid !== 1'b1) begin
                chk(1'b0, {nm, "_last_without_valid"}, 1, 0);
            end
            if (out_valid === 1'b1 && nhs >= v.exp_lanes && vld_extra == 0) begin
                vld_extra = 1;
                chk(1'b0, {nm, "_extra_valid"}, nhs + 1, v.exp_lanes);
            end
            if (out_valid === 1'b1 && out_ready && nhs < v.exp_lanes) begin
                ln = v.base + ADDR_W'(nhs / BURST_LEN);
                exp_word = DATA_W'(16 * int'(ln) + (nhs % BURST_LEN));
                chk(out_data === exp_word, {nm, "_data"}, int'(out_data), int'(exp_word));
                chk(out_last === (nhs == v.exp_lanes - 1), {nm, "_last"},
                    int'(out_last), int'(nhs == v.exp_lanes - 1));
                if (first_hs < 0) first_hs = t;
                last_hs = t;
                nhs++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_t = t;
                chk(busy === 1'b0, {nm, "_busy_with_done"}, int'(busy), 0);
            end
            prev_stall = out_valid & ~out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            @(negedge clk);
            t++;
        end
        start = 1'b0;

        chk(nhs == v.exp_lanes, {nm, "_lane_count"}, nhs, v.exp_lanes);
        chk(done_cnt == 1, {nm, "_done_count"}, done_cnt, 1);
        if (v.exp_lanes == 0)
            chk(done_t == 2, {nm, "_done_time"}, done_t, 2);
        else
            chk(done_t == last_hs + 1, {nm, "_done_time"}, done_t, last_hs + 1);
        if (!v.rand_ready && v.exp_lanes > 0) begin
            chk(first_hs == 3, {nm, "_first_latency"}, first_hs, 3);
            chk(last_hs == 3 + v.exp_lanes - 1, {nm, "_no_bubbles"}, last_hs, 3 + v.exp_lanes - 1);
        end
        chk(busy === 1'b0, {nm, "_busy_end"}, int'(busy), 0);
        chk(ram_rd_addr === v.exp_last_addr, {nm, "_last_rd_addr"},
            int'(ram_rd_addr), int'(v.exp_last_addr));
    endtask

    initial begin
        int hs;
        for (int k = 0; k < (1 << ADDR_W); k++)
            for (int l = 0; l < BURST_LEN; l++)
                mem[k][l*DATA_W +: DATA_W] = DATA_W'(16 * k + l);

        //          base     num     rand  rst_t lanes last_addr
        vecs[0] = '{10'd0,    11'd0, 1'b0, 0,    0,    10'd0};
        vecs[1] = '{10'd0,    11'd2, 1'b0, 0,    16,   10'd1};
        vecs[2] = '{10'd0,    11'd2, 1'b1, 0,    16,   10'd1};
        vecs[3] = '{10'd1023, 11'd3, 1'b0, 0,    24,   10'd1};
        vecs[4] = '{10'd0,    11'd2, 1'b0, 5,    16,   10'd1};
        vecs[5] = '{10'd5,    11'd1, 1'b1, 0,    8,    10'd5};
        vecs[6] = '{10'd0,    11'd4, 1'b0, 0,    32,   10'd3};

        repeat (3) @(negedge clk);
        chk(busy === 1'b0,        "rst_busy",      int'(busy), 0);
        chk(done === 1'b0,        "rst_done",      int'(done), 0);
        chk(out_valid === 1'b0,   "rst_out_valid", int'(out_valid), 0);
        chk(out_last === 1'b0,    "rst_out_last",  int'(out_last), 0);
        chk(out_data === '0,      "rst_out_data",  int'(out_data), 0);
        chk(ram_rd_addr === '0,   "rst_rd_addr",   int'(ram_rd_addr), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // Abort a 4-line burst after 5 lanes with an asynchronous reset.
        @(negedge clk);
        base_addr = 10'd0;
        num_lines = 11'd4;
        start     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hs = 0;
        for (int c = 0; c < 50 && hs < 5; c++) begin
            if (out_valid === 1'b1) hs++;
            @(negedge clk);
        end
        chk(hs == 5, "abort_reach_5_lanes", hs, 5);
        #2 rst = 1'b1;
        #1;
        chk(out_valid === 1'b0, "abort_out_valid", int'(out_valid), 0);
        chk(busy === 1'b0,      "abort_busy",      int'(busy), 0);
        chk(out_data === '0,    "abort_out_data",  int'(out_data), 0);
        chk(ram_rd_addr === '0, "abort_rd_addr",   int'(ram_rd_addr), 0);
        repeat (2) begin
            @(negedge clk);
            chk(done === 1'b0, "abort_no_done", int'(done), 0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk(done === 1'b0 && out_valid === 1'b0, "abort_idle_after",
                int'(done) + int'(out_valid), 0);
        end

        run_vec(vecs[6], 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
